// File: rtl/alarm_ctrl_pkg.sv
// Shared types, limits and field helpers for the alarm clock mode controller.
package alarm_ctrl_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;

    localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;
    localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;

    typedef enum logic [2:0] {
        ST_CLOCK,
        ST_SET_HR,
        ST_SET_MIN,
        ST_ALM_HR,
        ST_ALM_MIN
    } state_t;

    function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] v);
        return (v >= MAX_HR) ? '0 : v + 5'd1;
    endfunction

    function automatic logic [HR_W-1:0] hr_dec(input logic [HR_W-1:0] v);
        return (v == '0) ? MAX_HR : v - 5'd1;
    endfunction

    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
        return (v >= MAX_MIN) ? '0 : v + 6'd1;
    endfunction

    function automatic logic [MIN_W-1:0] min_dec(input logic [MIN_W-1:0] v);
        return (v == '0) ? MAX_MIN : v - 6'd1;
    endfunction

    function automatic logic is_set_state(input state_t s);
        return (s == ST_SET_HR) || (s == ST_SET_MIN);
    endfunction

    function automatic logic is_alm_state(input state_t s);
        return (s == ST_ALM_HR) || (s == ST_ALM_MIN);
    endfunction

    function automatic logic is_hr_state(input state_t s);
        return (s == ST_SET_HR) || (s == ST_ALM_HR);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running half-period timer producing the edit-field flash phase.
module blink_timer #(
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase
);

    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/alarm_mode_controller.sv
// Mode FSM for the alarm clock: time/alarm editing, timekeeper load, alarm match and buzzer.
module alarm_mode_controller
    import alarm_ctrl_pkg::*;
#(
    parameter int BLINK_HALF = 25_000_000,
    parameter int ALARM_SECS = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_btn_c,
    input  logic             i_btn_u,
    input  logic             i_btn_d,
    input  logic             i_btn_l,
    input  logic             i_btn_r,
    input  logic             i_sec_tick,
    input  logic [HR_W-1:0]  i_cur_hr,
    input  logic [MIN_W-1:0] i_cur_min,
    output logic             o_run_en,
    output logic             o_ld_en,
    output logic [HR_W-1:0]  o_ld_hr,
    output logic [MIN_W-1:0] o_ld_min,
    output logic [HR_W-1:0]  o_disp_hr,
    output logic [MIN_W-1:0] o_disp_min,
    output logic [3:0]       o_blink_mask,
    output logic             o_alm_view,
    output logic             o_armed,
    output logic             o_buzzer
);

    localparam int RING_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(ALARM_SECS - 1);

    state_t            r_state, w_nxt_state;
    logic [HR_W-1:0]   r_edit_hr, w_nxt_edit_hr;
    logic [MIN_W-1:0]  r_edit_min, w_nxt_edit_min;
    logic [HR_W-1:0]   r_alarm_hr, w_nxt_alarm_hr;
    logic [MIN_W-1:0]  r_alarm_min, w_nxt_alarm_min;
    logic              r_armed, w_nxt_armed;
    logic              r_buzzer, w_nxt_buzzer;
    logic [RING_W-1:0] r_ring_cnt, w_nxt_ring_cnt;
    logic              r_match_d;
    logic              r_run_en, r_ld_en;
    logic [HR_W-1:0]   r_ld_hr, r_disp_hr;
    logic [MIN_W-1:0]  r_ld_min, r_disp_min;
    logic [3:0]        r_blink_mask, w_nxt_mask;
    logic              r_alm_view;

    logic w_any_btn, w_load, w_match, w_trigger, w_state_chg, w_phase;

    assign w_any_btn   = i_btn_c | i_btn_r | i_btn_l | i_btn_u | i_btn_d;
    assign w_match     = r_armed && (i_cur_hr == r_alarm_hr) && (i_cur_min == r_alarm_min);
    assign w_trigger   = w_match && !r_match_d && (r_state == ST_CLOCK);
    assign w_state_chg = (w_nxt_state != r_state);

    blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_state_chg),
        .phase (w_phase)
    );

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_edit_hr   = r_edit_hr;
        w_nxt_edit_min  = r_edit_min;
        w_nxt_alarm_hr  = r_alarm_hr;
        w_nxt_alarm_min = r_alarm_min;
        w_nxt_armed     = r_armed;
        w_load          = 1'b0;

        // A press while ringing only silences; the buzzer block below handles it.
        if (!(r_buzzer && w_any_btn)) begin
            unique case (r_state)
                ST_CLOCK: begin
                    if (i_btn_c) begin
                        w_nxt_state    = ST_SET_HR;
                        w_nxt_edit_hr  = i_cur_hr;
                        w_nxt_edit_min = i_cur_min;
                    end else if (i_btn_r) begin
                        w_nxt_state = ST_CLOCK;
                    end else if (i_btn_l) begin
                        w_nxt_state    = ST_ALM_HR;
                        w_nxt_edit_hr  = r_alarm_hr;
                        w_nxt_edit_min = r_alarm_min;
                    end else if (i_btn_u) begin
                        w_nxt_armed = ~r_armed;
                    end
                end
                ST_SET_HR, ST_SET_MIN, ST_ALM_HR, ST_ALM_MIN: begin
                    if (i_btn_c) begin
                        w_nxt_state = ST_CLOCK;
                        if (is_set_state(r_state)) begin
                            w_load = 1'b1;
                        end else begin
                            w_nxt_alarm_hr  = r_edit_hr;
                            w_nxt_alarm_min = r_edit_min;
                        end
                    end else if (i_btn_r || i_btn_l) begin
                        unique case (r_state)
                            ST_SET_HR:  w_nxt_state = ST_SET_MIN;
                            ST_SET_MIN: w_nxt_state = ST_SET_HR;
                            ST_ALM_HR:  w_nxt_state = ST_ALM_MIN;
                            default:    w_nxt_state = ST_ALM_HR;
                        endcase
                    end else if (i_btn_u) begin
                        if (is_hr_state(r_state)) w_nxt_edit_hr  = hr_inc(r_edit_hr);
                        else                      w_nxt_edit_min = min_inc(r_edit_min);
                    end else if (i_btn_d) begin
                        if (is_hr_state(r_state)) w_nxt_edit_hr  = hr_dec(r_edit_hr);
                        else                      w_nxt_edit_min = min_dec(r_edit_min);
                    end
                end
                default: w_nxt_state = ST_CLOCK;
            endcase
        end
    end

    always_comb begin
        w_nxt_buzzer   = r_buzzer;
        w_nxt_ring_cnt = r_ring_cnt;
        if (w_trigger && w_nxt_armed) begin
            w_nxt_buzzer   = 1'b1;
            w_nxt_ring_cnt = '0;
        end else if (r_buzzer) begin
            if (w_any_btn || !w_nxt_armed) begin
                w_nxt_buzzer = 1'b0;
            end else if (i_sec_tick) begin
                if (r_ring_cnt == RING_LAST) w_nxt_buzzer   = 1'b0;
                else                         w_nxt_ring_cnt = r_ring_cnt + 1'b1;
            end
        end
    end

    // Mask follows the phase of the current state; a state change starts unblanked.
    always_comb begin
        w_nxt_mask = 4'b0000;
        if (!w_state_chg && w_phase && (r_state != ST_CLOCK)) begin
            w_nxt_mask = is_hr_state(r_state) ? 4'b1100 : 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_CLOCK;
            r_edit_hr    <= '0;
            r_edit_min   <= '0;
            r_alarm_hr   <= '0;
            r_alarm_min  <= '0;
            r_armed      <= 1'b0;
            r_buzzer     <= 1'b0;
            r_ring_cnt   <= '0;
            r_match_d    <= 1'b0;
            r_run_en     <= 1'b1;
            r_ld_en      <= 1'b0;
            r_ld_hr      <= '0;
            r_ld_min     <= '0;
            r_disp_hr    <= '0;
            r_disp_min   <= '0;
            r_blink_mask <= '0;
            r_alm_view   <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_edit_hr    <= w_nxt_edit_hr;
            r_edit_min   <= w_nxt_edit_min;
            r_alarm_hr   <= w_nxt_alarm_hr;
            r_alarm_min  <= w_nxt_alarm_min;
            r_armed      <= w_nxt_armed;
            r_buzzer     <= w_nxt_buzzer;
            r_ring_cnt   <= w_nxt_ring_cnt;
            r_match_d    <= w_match;
            r_run_en     <= !is_set_state(w_nxt_state);
            r_ld_en      <= w_load;
            if (w_load) begin
                r_ld_hr  <= r_edit_hr;
                r_ld_min <= r_edit_min;
            end
            if (w_nxt_state == ST_CLOCK) begin
                r_disp_hr  <= i_cur_hr;
                r_disp_min <= i_cur_min;
            end else begin
                r_disp_hr  <= w_nxt_edit_hr;
                r_disp_min <= w_nxt_edit_min;
            end
            r_blink_mask <= w_nxt_mask;
            r_alm_view   <= is_alm_state(w_nxt_state);
        end
    end

    assign o_run_en     = r_run_en;
    assign o_ld_en      = r_ld_en;
    assign o_ld_hr      = r_ld_hr;
    assign o_ld_min     = r_ld_min;
    assign o_disp_hr    = r_disp_hr;
    assign o_disp_min   = r_disp_min;
    assign o_blink_mask = r_blink_mask;
    assign o_alm_view   = r_alm_view;
    assign o_armed      = r_armed;
    assign o_buzzer     = r_buzzer;

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Directed, table-driven bench for alarm_mode_controller (BLINK_HALF=4, ALARM_SECS=3).
module tb_alarm_mode_controller;

    localparam logic [4:0] B_0 = 5'b00000;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_R = 5'b01000;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    typedef struct packed {
        logic [4:0] btn;
        logic [4:0] hr;
        logic [5:0] mn;
        logic [4:0] e_dhr;
        logic [5:0] e_dmin;
        logic       e_run;
        logic       e_ld;
        logic [4:0] e_ldhr;
        logic [5:0] e_ldmin;
        logic       e_view;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_c, btn_u, btn_d, btn_l, btn_r, sec_tick;
    logic [4:0] cur_hr;
    logic [5:0] cur_min;
    logic       run_en, ld_en, alm_view, armed, buzzer;
    logic [4:0] ld_hr, disp_hr;
    logic [5:0] ld_min, disp_min;
    logic [3:0] blink_mask;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alarm_mode_controller #(.BLINK_HALF(4), .ALARM_SECS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_btn_c      (btn_c),
        .i_btn_u      (btn_u),
        .i_btn_d      (btn_d),
        .i_btn_l      (btn_l),
        .i_btn_r      (btn_r),
        .i_sec_tick   (sec_tick),
        .i_cur_hr     (cur_hr),
        .i_cur_min    (cur_min),
        .o_run_en     (run_en),
        .o_ld_en      (ld_en),
        .o_ld_hr      (ld_hr),
        .o_ld_min     (ld_min),
        .o_disp_hr    (disp_hr),
        .o_disp_min   (disp_min),
        .o_blink_mask (blink_mask),
        .o_alm_view   (alm_view),
        .o_armed      (armed),
        .o_buzzer     (buzzer)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive a button pattern for one clock, sample #1 after the edge.
    task automatic step(input logic [4:0] b);
        {btn_c, btn_r, btn_l, btn_u, btn_d} = b;
        @(posedge clk);
        #1;
        {btn_c, btn_r, btn_l, btn_u, btn_d} = B_0;
    endtask

    task automatic sec_pulse();
        sec_tick = 1'b1;
        step(B_0);
        sec_tick = 1'b0;
    endtask

    function automatic vec_t mk(input logic [4:0] b, input logic [4:0] h, input logic [5:0] m,
                                input logic [4:0] dh, input logic [5:0] dm, input logic run,
                                input logic ld, input logic [4:0] lh, input logic [5:0] lm,
                                input logic view);
        vec_t v;
        v = '{btn: b, hr: h, mn: m, e_dhr: dh, e_dmin: dm, e_run: run, e_ld: ld,
              e_ldhr: lh, e_ldmin: lm, e_view: view};
        return v;
    endfunction

    vec_t tbl[$];
    logic [3:0] mask_s[1:16];
    int trans[$];

    initial begin
        rst = 1'b1;
        {btn_c, btn_r, btn_l, btn_u, btn_d} = B_0;
        sec_tick = 1'b0;
        cur_hr   = 5'd13;
        cur_min  = 6'd45;

        // Reset values while reset is held.
        #12;
        check("rst_run_en", run_en, 1);
        check("rst_ld_en", ld_en, 0);
        check("rst_armed", armed, 0);
        check("rst_buzzer", buzzer, 0);
        check("rst_mask", blink_mask, 0);
        check("rst_alm_view", alm_view, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Time-set editing, priority and CLOCK no-op buttons.
        tbl.push_back(mk(B_0, 13, 45, 13, 45, 1, 0, 0, 0, 0));
        tbl.push_back(mk(B_C, 13, 45, 13, 45, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 11; i++)
            tbl.push_back(mk(B_U, 13, 45, 5'((13 + i) % 24), 45, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_D, 10, 10, 23, 45, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B_C, 10, 10, 10, 10, 1, 1, 23, 45, 0));
        tbl.push_back(mk(B_0, 10, 10, 10, 10, 1, 0, 23, 45, 0));
        tbl.push_back(mk(B_R, 10, 10, 10, 10, 1, 0, 23, 45, 0));
        tbl.push_back(mk(B_D, 10, 10, 10, 10, 1, 0, 23, 45, 0));
        tbl.push_back(mk(B_C, 10, 10, 10, 10, 0, 0, 23, 45, 0));
        tbl.push_back(mk(B_R | B_U, 10, 10, 10, 10, 0, 0, 23, 45, 0));
        tbl.push_back(mk(B_U, 10, 10, 10, 11, 0, 0, 23, 45, 0));
        tbl.push_back(mk(B_L | B_D, 10, 10, 10, 11, 0, 0, 23, 45, 0));
        tbl.push_back(mk(B_U, 10, 10, 11, 11, 0, 0, 23, 45, 0));
        tbl.push_back(mk(B_L, 10, 10, 11, 11, 0, 0, 23, 45, 0));
        tbl.push_back(mk(B_D, 10, 10, 11, 10, 0, 0, 23, 45, 0));
        tbl.push_back(mk(B_C, 10, 10, 10, 10, 1, 1, 11, 10, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cur_hr  = tbl[i].hr;
            cur_min = tbl[i].mn;
            step(tbl[i].btn);
            check($sformatf("v%0d_disp_hr", i), disp_hr, tbl[i].e_dhr);
            check($sformatf("v%0d_disp_min", i), disp_min, tbl[i].e_dmin);
            check($sformatf("v%0d_run_en", i), run_en, tbl[i].e_run);
            check($sformatf("v%0d_ld_en", i), ld_en, tbl[i].e_ld);
            check($sformatf("v%0d_ld", i), {ld_hr, ld_min}, {tbl[i].e_ldhr, tbl[i].e_ldmin});
            check($sformatf("v%0d_alm_view", i), alm_view, tbl[i].e_view);
        end

        // Minute wrap and blink cadence in SET_MIN.
        cur_hr  = 5'd7;
        cur_min = 6'd59;
        step(B_0);
        step(B_C);
        step(B_R);
        step(B_U);
        mask_s[1] = blink_mask;
        check("min_wrap_up", {disp_hr, disp_min}, {5'd7, 6'd0});
        step(B_D);
        mask_s[2] = blink_mask;
        check("min_wrap_down", {disp_hr, disp_min}, {5'd7, 6'd59});
        for (int j = 3; j <= 16; j++) begin
            step(B_0);
            mask_s[j] = blink_mask;
        end
        check("blink_start_clear", mask_s[1], 4'b0000);
        for (int j = 2; j <= 16; j++) begin
            if (mask_s[j] != 4'b0000 && mask_s[j] != 4'b0011)
                check($sformatf("blink_value_%0d", j), mask_s[j], 4'b0011);
            if (mask_s[j] != mask_s[j-1]) trans.push_back(j);
        end
        check("blink_transitions", (trans.size() >= 3), 1);
        if (trans.size() > 0) check("blink_first_toggle", (trans[0] >= 4 && trans[0] <= 5), 1);
        for (int k = 1; k < trans.size(); k++)
            check($sformatf("blink_gap_%0d", k), trans[k] - trans[k-1], 4);
        step(B_C);
        check("min_commit_ld", {ld_en, ld_hr, ld_min}, {1'b1, 5'd7, 6'd59});

        // Alarm editing 06:30.
        step(B_L);
        check("alm_enter_view", alm_view, 1);
        check("alm_enter_disp", {disp_hr, disp_min}, {5'd0, 6'd0});
        step(B_R);
        step(B_L);
        for (int i = 0; i < 6; i++) step(B_U);
        step(B_R);
        for (int i = 0; i < 30; i++) step(B_U);
        check("alm_edit_disp", {disp_hr, disp_min}, {5'd6, 6'd30});
        check("alm_edit_run_en", run_en, 1);
        check("alm_edit_mask_hr_untouched", disp_hr, 6);
        cur_hr  = 5'd6;
        cur_min = 6'd29;
        step(B_C);
        check("alm_commit_view", alm_view, 0);
        check("alm_commit_no_ld", ld_en, 0);
        check("alm_commit_disp_cur", {disp_hr, disp_min}, {5'd6, 6'd29});
        step(B_U);
        check("arm", armed, 1);
        check("no_ring_before_match", buzzer, 0);

        // Match, auto-silence after three ticks, no retrigger while held.
        cur_min = 6'd30;
        step(B_0);
        check("ring_start", buzzer, 1);
        sec_pulse();
        check("ring_tick1", buzzer, 1);
        sec_pulse();
        check("ring_tick2", buzzer, 1);
        sec_pulse();
        check("ring_tick3_silent", buzzer, 0);
        for (int i = 0; i < 6; i++) step(B_0);
        check("no_retrigger", buzzer, 0);

        // Retrigger restarts the ring counter; a press silences only.
        cur_min = 6'd31;
        step(B_0);
        cur_min = 6'd30;
        step(B_0);
        check("retrigger", buzzer, 1);
        sec_pulse();
        sec_pulse();
        check("ring_counter_restarted", buzzer, 1);
        step(B_C);
        check("press_silences", buzzer, 0);
        check("press_stays_clock", run_en, 1);
        check("press_keeps_armed", armed, 1);
        step(B_C | B_U);
        check("c_over_u_state", run_en, 0);
        check("c_over_u_armed", armed, 1);

        // Reset mid-edit in SET_MIN.
        step(B_R);
        step(B_U);
        check("edit_before_rst", {disp_hr, disp_min}, {5'd6, 6'd31});
        #2 rst = 1'b1;
        #1;
        check("mid_rst_run_en", run_en, 1);
        check("mid_rst_ld_en", ld_en, 0);
        check("mid_rst_armed", armed, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(B_0);
            check($sformatf("post_rst_no_ld_%0d", i), ld_en, 0);
        end
        check("post_rst_run_en", run_en, 1);
        step(B_L);
        check("post_rst_alarm", {disp_hr, disp_min}, {5'd0, 6'd0});
        check("post_rst_view", alm_view, 1);
        check("post_rst_armed", armed, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
